// File: rtl/vram_pkg.sv
// Shared types and default widths for the VRAM arbiter slice.
package vram_pkg;

    localparam int VRAM_ADDRESS_WIDTH = 13;
    localparam int VRAM_DATA_WIDTH    = 8;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_VIDEO = 2'd1,
        OWNER_CPU   = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        VIDEO_READ = 2'd1,
        CPU_READ   = 2'd2,
        CPU_WRITE  = 2'd3
    } command_e;

    // Only reads produce return data, so writes and idle slots map to no owner.
    function automatic owner_e command_owner(input command_e command);
        case (command)
            VIDEO_READ: return OWNER_VIDEO;
            CPU_READ:   return OWNER_CPU;
            default:    return OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Video fetch, CPU bus and VRAM macro signals seen by the arbiter (slave) and its surroundings (master).
interface vram_arbiter_if
    import vram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = VRAM_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = VRAM_DATA_WIDTH
);
    logic                     video_request;
    logic [ADDRESS_WIDTH-1:0] video_address;
    logic [DATA_WIDTH-1:0]    video_data;
    logic                     video_data_valid;

    logic                     cpu_valid;
    logic                     cpu_ready;
    logic                     cpu_write;
    logic [ADDRESS_WIDTH-1:0] cpu_address;
    logic [DATA_WIDTH-1:0]    cpu_write_data;
    logic [DATA_WIDTH-1:0]    cpu_read_data;
    logic                     cpu_read_valid;

    logic                     ram_enable;
    logic                     ram_write;
    logic [ADDRESS_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0]    ram_write_data;
    logic [DATA_WIDTH-1:0]    ram_read_data;

    modport slave (
        input  video_request, video_address,
        input  cpu_valid, cpu_write, cpu_address, cpu_write_data,
        input  ram_read_data,
        output video_data, video_data_valid,
        output cpu_ready, cpu_read_data, cpu_read_valid,
        output ram_enable, ram_write, ram_address, ram_write_data
    );

    modport master (
        output video_request, video_address,
        output cpu_valid, cpu_write, cpu_address, cpu_write_data,
        output ram_read_data,
        input  video_data, video_data_valid,
        input  cpu_ready, cpu_read_data, cpu_read_valid,
        input  ram_enable, ram_write, ram_address, ram_write_data
    );

endinterface

// File: rtl/vram_write_buffer.sv
// One-entry posted CPU write holding register; only used when VRAM_ARBITER_WRITE_BUFFER_EN is defined.
module vram_write_buffer
    import vram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = VRAM_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = VRAM_DATA_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [ADDRESS_WIDTH-1:0] push_address_i,
    input  logic [DATA_WIDTH-1:0]    push_data_i,
    input  logic                     drain_i,
    output logic                     full_o,
    output logic [ADDRESS_WIDTH-1:0] address_o,
    output logic [DATA_WIDTH-1:0]    data_o
);
    logic                     valid_q, valid_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            address_q <= '0;
            data_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            address_q <= address_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        address_d = address_q;
        data_d    = data_q;
        if (drain_i) begin
            valid_d = 1'b0;
        end
        if (push_i) begin
            valid_d   = 1'b1;
            address_d = push_address_i;
            data_d    = push_data_i;
        end
    end

    assign full_o    = valid_q;
    assign address_o = address_q;
    assign data_o    = data_q;

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: video fetch has absolute priority and fixed 2-cycle latency, the CPU uses idle slots.
// Define VRAM_ARBITER_WRITE_BUFFER_EN to add a one-entry posted CPU write buffer.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = VRAM_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = VRAM_DATA_WIDTH
) (
    input  logic          clock,
    input  logic          reset_n,
    vram_arbiter_if.slave bus
);
    command_e                 command_q, command_d;
    owner_e                   owner_q, owner_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
    logic [DATA_WIDTH-1:0]    video_hold_q, video_hold_d;
    logic [DATA_WIDTH-1:0]    cpu_hold_q, cpu_hold_d;
    logic                     read_pending_q, read_pending_d;
    logic                     video_return;
    logic                     cpu_return;
    logic                     cpu_ready;
    logic                     cpu_accept;

    assign video_return = (owner_q == OWNER_VIDEO);
    assign cpu_return   = (owner_q == OWNER_CPU);

`ifdef VRAM_ARBITER_WRITE_BUFFER_EN
    logic                     buffer_full;
    logic                     buffer_push;
    logic                     buffer_drain;
    logic [ADDRESS_WIDTH-1:0] buffer_address;
    logic [DATA_WIDTH-1:0]    buffer_data;

    vram_write_buffer #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_write_buffer (
        .clock         (clock),
        .reset_n       (reset_n),
        .push_i        (buffer_push),
        .push_address_i(bus.cpu_address),
        .push_data_i   (bus.cpu_write_data),
        .drain_i       (buffer_drain),
        .full_o        (buffer_full),
        .address_o     (buffer_address),
        .data_o        (buffer_data)
    );

    // Reads wait for an occupied buffer so they can never overtake a posted write.
    assign cpu_ready = reset_n && !read_pending_q && !buffer_full
                       && (bus.cpu_write || !bus.video_request);
`else
    assign cpu_ready = reset_n && !bus.video_request && !read_pending_q;
`endif

    assign cpu_accept = bus.cpu_valid && cpu_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            command_q      <= IDLE;
            owner_q        <= OWNER_NONE;
            address_q      <= '0;
            write_data_q   <= '0;
            video_hold_q   <= '0;
            cpu_hold_q     <= '0;
            read_pending_q <= 1'b0;
        end else begin
            command_q      <= command_d;
            owner_q        <= owner_d;
            address_q      <= address_d;
            write_data_q   <= write_data_d;
            video_hold_q   <= video_hold_d;
            cpu_hold_q     <= cpu_hold_d;
            read_pending_q <= read_pending_d;
        end
    end

    // The pending read clears in the cycle its data returns, so the next CPU grant lands one cycle later.
    always_comb begin
        command_d      = IDLE;
        address_d      = address_q;
        write_data_d   = write_data_q;
        read_pending_d = read_pending_q && !cpu_return;
`ifdef VRAM_ARBITER_WRITE_BUFFER_EN
        buffer_push    = 1'b0;
        buffer_drain   = 1'b0;
`endif
        if (bus.video_request) begin
            command_d = VIDEO_READ;
            address_d = bus.video_address;
`ifdef VRAM_ARBITER_WRITE_BUFFER_EN
            buffer_push = cpu_accept;
        end else if (buffer_full) begin
            command_d    = CPU_WRITE;
            address_d    = buffer_address;
            write_data_d = buffer_data;
            buffer_drain = 1'b1;
`endif
        end else if (cpu_accept) begin
            address_d = bus.cpu_address;
            if (bus.cpu_write) begin
                command_d    = CPU_WRITE;
                write_data_d = bus.cpu_write_data;
            end else begin
                command_d      = CPU_READ;
                read_pending_d = 1'b1;
            end
        end
    end

    assign owner_d      = command_owner(command_q);
    assign video_hold_d = video_return ? bus.ram_read_data : video_hold_q;
    assign cpu_hold_d   = cpu_return ? bus.ram_read_data : cpu_hold_q;

    assign bus.ram_enable       = (command_q != IDLE);
    assign bus.ram_write        = (command_q == CPU_WRITE);
    assign bus.ram_address      = address_q;
    assign bus.ram_write_data   = write_data_q;
    assign bus.video_data_valid = video_return;
    assign bus.video_data       = video_hold_d;
    assign bus.cpu_read_valid   = cpu_return;
    assign bus.cpu_read_data    = cpu_hold_d;
    assign bus.cpu_ready        = cpu_ready;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between the video_generator pixel fetch (read-only, hard real-time) and the CPU bus (read/write, valid/ready).
- Video fetch has absolute priority and fixed latency, so raster output never slips. The CPU uses the idle cycles.
- Sits between video_generator, the CPU bus bridge and the VRAM macro.

Parameters:
- ADDRESS_WIDTH, 13, VRAM word address width.
- DATA_WIDTH, 8, VRAM word width.

Ports:
- clock  in  1  system clock (same clock as video_generator)
- reset_n  in  1  asynchronous active-low reset
- video_request  in  1  video fetch request this cycle
- video_address  in  ADDRESS_WIDTH  fetch address
- video_data  out  DATA_WIDTH  fetched word
- video_data_valid  out  1  video_data valid this cycle
- cpu_valid  in  1  CPU request valid
- cpu_ready  out  1  arbiter accepts CPU request this cycle
- cpu_write  in  1  1 = write, 0 = read
- cpu_address  in  ADDRESS_WIDTH  CPU address
- cpu_write_data  in  DATA_WIDTH  CPU write data
- cpu_read_data  out  DATA_WIDTH  CPU read result
- cpu_read_valid  out  1  cpu_read_data valid, one-cycle pulse
- ram_enable  out  1  RAM access strobe
- ram_write  out  1  RAM write enable
- ram_address  out  ADDRESS_WIDTH  RAM address
- ram_write_data  out  DATA_WIDTH  RAM write data
- ram_read_data  in  DATA_WIDTH  RAM read data, valid the cycle after a read strobe

Behaviour:
- Reset: all outputs 0 asynchronously. Pending CPU read is dropped with no cpu_read_valid. Command register goes to IDLE.
- Cycle N is the grant decision. Cycle N+1 drives the registered RAM command. Cycle N+2 returns read data.
- Command state machine (registered): IDLE, VIDEO_READ, CPU_READ, CPU_WRITE. Next state is chosen every cycle:
  - video_request=1 -> VIDEO_READ (address = video_address).
  - else cpu_valid && cpu_ready -> CPU_READ or CPU_WRITE.
  - else IDLE.
- Return tag pipeline: a 2-bit owner tag follows the command one cycle.
  - Owner video: video_data = ram_read_data, video_data_valid = 1.
  - Owner CPU: cpu_read_data = ram_read_data, cpu_read_valid = 1.
  - Data outputs hold their last value when not valid.
- Video latency is exactly 2 cycles from request, in every case. Back-to-back video requests every cycle are legal.
- cpu_ready = !video_request && !cpu_read_pending.
  - cpu_ready is combinational from video_request and internal state only. It never depends on cpu_valid.
- cpu_read_pending: set on CPU read acceptance, cleared in the cycle cpu_read_valid pulses. At most one CPU read is outstanding.
  - The earliest next CPU acceptance is the cycle after cpu_read_valid.
- CPU write acceptance: RAM write issued the next cycle (ram_enable=1, ram_write=1). No response pulse.
- CPU inputs must hold stable while cpu_valid=1 && cpu_ready=0.
- Simultaneous video_request and cpu_valid: video wins. The CPU request stays pending with no loss and no duplication.
- Starvation: continuous video_request starves the CPU indefinitely. The video side guarantees gaps (blanking, inter-fetch slots).
- Address and data widths are passed through unmodified. There is no address arithmetic.

Optional Feature:
- Macro: VRAM_ARBITER_WRITE_BUFFER_EN
- Defined: adds a one-entry posted write buffer.
  - A CPU write is accepted while video_request=1 if the buffer is empty.
  - The buffer drains on the first cycle with video_request=0, with priority over new CPU requests that cycle.
  - A CPU write with a full buffer: cpu_ready=0.
  - A CPU read: cpu_ready=0 while the buffer is occupied, which keeps read-after-write ordering.
  - Reset discards buffer contents.
- Undefined: writes follow the base rule, ready only when video_request=0. No buffer registers exist.

Decomposition:
- Package vram_pkg:
  - owner enum (OWNER_NONE, OWNER_VIDEO, OWNER_CPU)
  - command state enum (IDLE, VIDEO_READ, CPU_READ, CPU_WRITE)
  - default ADDRESS_WIDTH and DATA_WIDTH constants
- Sub-module vram_write_buffer: one-entry valid/address/data register with push, drain and full. Instantiated only under VRAM_ARBITER_WRITE_BUFFER_EN.

Test Plan:
- Reset mid-read: CPU read 0x0040 accepted, reset_n low the next cycle -> all outputs 0, no cpu_read_valid after release.
- Video only: requests at 0x0000..0x0003 on consecutive cycles, RAM preloaded 0xA0..0xA3 -> video_data_valid high 4 cycles starting 2 cycles after the first request, data 0xA0..0xA3 in order.
- Collision: video_request and CPU read 0x1FFF (0x5A) in the same cycle -> video served first. CPU accepted the next idle cycle; cpu_read_valid 2 cycles after acceptance with 0x5A.
- CPU write/read: write 0x0123 <- 0x3C, then read 0x0123 -> ram_write one cycle after acceptance; read returns 0x3C; cpu_ready low until cpu_read_valid.
- Video burst: 2032-cycle line with video_request high for 1600 cycles and a pending CPU write -> write issued within 1 cycle of the burst end, no video latency change.
- VRAM_ARBITER_WRITE_BUFFER_EN: CPU write 0x0010 <- 0x77 during video_request -> accepted at once; RAM write on the first gap cycle; a following CPU read of 0x0010 stalls until the drain, then returns 0x77.
